// File: rtl/vcb_ctr_pkg.sv
// Shared constants for the vcb cascadable counter family.
// Holds the default counter width, the terminal values for that width
// and the direction encoding of the 'up' input.
package vcb_ctr_pkg;

  localparam int VCB_WIDTH = 4;

  localparam logic [VCB_WIDTH-1:0] VCB_ALL_ONES = {VCB_WIDTH{1'b1}};
  localparam logic [VCB_WIDTH-1:0] VCB_ZERO     = {VCB_WIDTH{1'b0}};

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/vcb_tc_detect.sv
// Terminal-count detector for the vcb counter family.
// Flags the value at which the next count step in the current direction
// wraps: all ones when counting up, zero when counting down.
module vcb_tc_detect
  import vcb_ctr_pkg::*;
#(
  parameter int WIDTH = VCB_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic             tc
);

  // Terminal value depends only on the present count and direction
  always_comb begin
    tc = 1'b0;
    if (up == DIR_UP) begin
      tc = (q == {WIDTH{1'b1}});
    end else begin
      tc = (q == {WIDTH{1'b0}});
    end
  end

endmodule

// File: rtl/vcb4cled_ctr.sv
// Cascadable up/down binary counter with clock enable, synchronous load
// and asynchronous clear. TC marks the wrap point for the current
// direction and CEO = ce & TC enables the next stage of a wider chain.
// Build option: define VCB_CTR_SAT_EN to make counting saturate at the
// terminal value instead of wrapping; load, clear, TC and CEO unchanged.
module vcb4cled_ctr
  import vcb_ctr_pkg::*;
#(
  parameter int WIDTH = VCB_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             up,
  input  logic [WIDTH-1:0] di,
  input  logic             L,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_w;

  vcb_tc_detect #(
    .WIDTH(WIDTH)
  ) u_tc_detect (
    .q  (q_q),
    .up (up),
    .tc (tc_w)
  );

  // Next count: load beats counting, counting needs ce, otherwise hold
  always_comb begin
    q_d = q_q;
    if (L) begin
      q_d = di;
    end else if (ce) begin
`ifdef VCB_CTR_SAT_EN
      if (!tc_w) begin
        q_d = (up == DIR_UP) ? (q_q + ONE) : (q_q - ONE);
      end
`else
      q_d = (up == DIR_UP) ? (q_q + ONE) : (q_q - ONE);
`endif
    end
  end

  // Count register; clear acts immediately and overrides everything
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q   = q_q;
  assign TC  = tc_w;
  assign CEO = ce & tc_w;

endmodule

// File: tb/tb_vcb4cled_ctr.sv
// Self-checking bench for vcb4cled_ctr (default WIDTH of 4).
// An integer reference model tracks the count from the behavioural rules;
// a negedge monitor compares Q/TC/CEO against it every cycle, and a
// directed sequence pins known values before a randomized phase.
module tb_vcb4cled_ctr;

  logic       clk;
  logic       clr;
  logic       ce;
  logic       up;
  logic [3:0] di;
  logic       L;
  logic [3:0] Q;
  logic       TC;
  logic       CEO;

  int total;
  int bad;
  int model_q;
  bit mon_en;

  vcb4cled_ctr dut (
    .clk (clk),
    .clr (clr),
    .ce  (ce),
    .up  (up),
    .di  (di),
    .L   (L),
    .Q   (Q),
    .TC  (TC),
    .CEO (CEO)
  );

  // 20 ns clock, rising edges at 10, 30, 50, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference count computed with plain modulo-16 arithmetic
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      model_q <= 0;
    end else if (L) begin
      model_q <= int'(di);
    end else if (ce) begin
`ifdef VCB_CTR_SAT_EN
      if (up && model_q != 15) model_q <= model_q + 1;
      else if (!up && model_q != 0) model_q <= model_q - 1;
`else
      if (up) model_q <= (model_q + 1) % 16;
      else model_q <= (model_q + 15) % 16;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change shortly after the falling edge, clear of both edges
  task automatic applyStimulus(input logic l_v, input logic ce_v,
                               input logic up_v, input logic [3:0] di_v);
    @(negedge clk);
    #2;
    L  = l_v;
    ce = ce_v;
    up = up_v;
    di = di_v;
  endtask

  // Every-cycle comparison against the reference model
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("mon_q", {28'd0, Q}, model_q);
      checkOutput("mon_tc", {31'd0, TC},
                  ((up && model_q == 15) || (!up && model_q == 0)) ? 1 : 0);
      checkOutput("mon_ceo", {31'd0, CEO},
                  (ce && ((up && model_q == 15) || (!up && model_q == 0))) ? 1 : 0);
    end
  end

  initial begin
    total  = 0;
    bad    = 0;
    mon_en = 1'b0;
    clr = 1'b1;
    ce  = 1'b1;
    up  = 1'b1;
    L   = 1'b0;
    di  = 4'd0;

    // Clear held across an edge keeps Q at zero
    #15;
    checkOutput("reset_q", {28'd0, Q}, 0);
    checkOutput("reset_tc", {31'd0, TC}, 0);
    mon_en = 1'b1;
    #10;
    clr = 1'b0;

    // Count up from 0: fifteen edges reach 15
    repeat (15) @(posedge clk);
    #1;
    checkOutput("up_q15", {28'd0, Q}, 15);
    checkOutput("up_tc15", {31'd0, TC}, 1);
    checkOutput("up_ceo15", {31'd0, CEO}, 1);
    @(posedge clk);
    #1;
`ifdef VCB_CTR_SAT_EN
    checkOutput("sat_hold15", {28'd0, Q}, 15);
`else
    checkOutput("wrap_q0", {28'd0, Q}, 0);
    checkOutput("wrap_tc0", {31'd0, TC}, 0);
`endif

    // Long run to 75 edges, then clear asynchronously mid-cycle
    repeat (59) @(posedge clk);
    #1;
`ifdef VCB_CTR_SAT_EN
    checkOutput("long_q", {28'd0, Q}, 15);
`else
    checkOutput("long_q", {28'd0, Q}, 11);
`endif
    #3;
    clr = 1'b1;
    #1;
    checkOutput("async_clr", {28'd0, Q}, 0);
    @(negedge clk);
    #2;
    clr = 1'b0;

    // Down count from a loaded 2
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("dn_q2", {28'd0, Q}, 2);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("dn_q0", {28'd0, Q}, 0);
    checkOutput("dn_tc0", {31'd0, TC}, 1);
    @(posedge clk);
    #1;
`ifdef VCB_CTR_SAT_EN
    checkOutput("sat_hold0", {28'd0, Q}, 0);
`else
    checkOutput("dn_wrap15", {28'd0, Q}, 15);
    checkOutput("dn_wrap_tc", {31'd0, TC}, 0);
`endif

    // Enable gating at 15 counting up
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd15);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    @(posedge clk);
    #1;
    checkOutput("gate_hold", {28'd0, Q}, 15);
    checkOutput("gate_tc", {31'd0, TC}, 1);
    checkOutput("gate_ceo0", {31'd0, CEO}, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
    #1;
    checkOutput("gate_ceo1", {31'd0, CEO}, 1);
    @(posedge clk);
    #1;
`ifdef VCB_CTR_SAT_EN
    checkOutput("gate_next", {28'd0, Q}, 15);
`else
    checkOutput("gate_next", {28'd0, Q}, 0);
`endif

    // Load beats increment, and clear beats load
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd9);
    @(posedge clk);
    #1;
    checkOutput("load_prio", {28'd0, Q}, 9);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7);
    clr = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("clr_over_load", {28'd0, Q}, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
    clr = 1'b0;

    // Randomized phase checked by the monitor
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom), 4'($urandom));
      clr = ($urandom_range(0, 39) == 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
    clr = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
